// File: rtl/quadrabuf_pkg.sv
// Shared types for the quad buffer and its sequencer: controller states,
// config field widths and the packed config layout {nCol, nRep, nPeriod, nData}.
package quadrabuf_pkg;

  localparam int nCOL_W    = 2;
  localparam int nDATA_W   = $clog2(1024);
  localparam int nREP_W    = $clog2(1024);
  localparam int nPERIOD_W = $clog2(524288);
  localparam int CW        = nCOL_W + nREP_W + nPERIOD_W + nDATA_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DONE,
    ST_ABORT
  } qb_state_e;

  typedef struct packed {
    logic [nCOL_W-1:0]    nCol;
    logic [nREP_W-1:0]    nRep;
    logic [nPERIOD_W-1:0] nPeriod;
    logic [nDATA_W-1:0]   nData;
  } qb_cfg_t;

  // Split a flat config word (MSB first) into its named fields.
  function automatic qb_cfg_t qb_cfg_unpack(input logic [CW-1:0] bits);
    qb_cfg_t c;
    c = qb_cfg_t'(bits);
    return c;
  endfunction

endpackage

// File: rtl/quadrabuf_ctrl_stats.sv
// Saturating stall counters for the sequencer's write and read ports.
// Only instantiated when QUADRABUF_CTRL_STATS_EN is defined.
module quadrabuf_ctrl_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        wr_stall_i,
  input  logic        rd_stall_i,
  output logic [31:0] wr_stall_cnt_o,
  output logic [31:0] rd_stall_cnt_o
);

  logic [31:0] wr_cnt_q, rd_cnt_q;

  // Count upstream stalls, holding at all-ones; a new job clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          wr_cnt_q <= '0;
    else if (clr_i)                    wr_cnt_q <= '0;
    else if (wr_stall_i && ~&wr_cnt_q) wr_cnt_q <= wr_cnt_q + 32'd1;
  end

  // Count downstream stalls, holding at all-ones; a new job clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          rd_cnt_q <= '0;
    else if (clr_i)                    rd_cnt_q <= '0;
    else if (rd_stall_i && ~&rd_cnt_q) rd_cnt_q <= rd_cnt_q + 32'd1;
  end

  assign wr_stall_cnt_o = wr_cnt_q;
  assign rd_stall_cnt_o = rd_cnt_q;

endmodule

// File: rtl/quadrabuf_ctrl.sv
// Quad buffer sequencer: takes a job config, starts the buffer, bridges the
// upstream write stream and downstream read stream onto the buffer strobes,
// and counts swcol reads to find the end of the job. Abort holds the buffer
// in reset for two cycles. Optional stall counters: QUADRABUF_CTRL_STATS_EN.
module quadrabuf_ctrl #(
  parameter  int DATA_WIDTH  = 16,
  parameter  int MAX_nDATA   = 1024,
  parameter  int MAX_nREP    = 1024,
  parameter  int MAX_nPERIOD = 524288,
  localparam int NDAT_W      = $clog2(MAX_nDATA),
  localparam int NREP_W      = $clog2(MAX_nREP),
  localparam int NPER_W      = $clog2(MAX_nPERIOD),
  localparam int CW          = 2 + NREP_W + NPER_W + NDAT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CW-1:0]         cfg_bits,
  input  logic                  abort,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  snk_valid,
  output logic [DATA_WIDTH-1:0] snk_data,
  input  logic                  snk_ready,
  output logic                  snk_nxcol,
  output logic                  qb_rst_n,
  output logic [CW-1:0]         qb_config_bits,
  output logic                  qb_start,
  output logic                  qb_we,
  output logic                  qb_re,
  output logic [DATA_WIDTH-1:0] qb_data_in,
  input  logic                  qb_wrdy,
  input  logic                  qb_rrdy,
  input  logic                  qb_swcol,
  input  logic                  qb_nxcol,
  input  logic [DATA_WIDTH-1:0] qb_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
`ifdef QUADRABUF_CTRL_STATS_EN
  ,
  output logic [31:0]           wr_stall_cnt,
  output logic [31:0]           rd_stall_cnt
`endif
);

  import quadrabuf_pkg::*;

  qb_state_e         state_q, state_d;
  logic [CW-1:0]     cfg_reg_q, cfg_reg_d;
  logic [NPER_W-1:0] period_cnt_q, period_cnt_d;
  logic              abort_cnt_q, abort_cnt_d;
  logic              cfg_err_q, cfg_err_d;
  logic              abort_hold;

  // Config fields of the incoming word (for the zero check) and of the
  // latched job (for end-of-job detection).
  logic [1:0]        in_ncol;
  logic [NREP_W-1:0] in_nrep;
  logic [NPER_W-1:0] in_nper, nper_m1;
  logic [NDAT_W-1:0] in_ndat;
  logic              cfg_bad;

  assign in_ncol = cfg_bits[CW-1 -: 2];
  assign in_nrep = cfg_bits[NDAT_W+NPER_W +: NREP_W];
  assign in_nper = cfg_bits[NDAT_W +: NPER_W];
  assign in_ndat = cfg_bits[NDAT_W-1:0];
  assign cfg_bad = (in_ncol == '0) || (in_nrep == '0) || (in_nper == '0) || (in_ndat == '0);
  assign nper_m1 = cfg_reg_q[NDAT_W +: NPER_W] - NPER_W'(1);

  // Controller state, latched job config and period/abort counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cfg_reg_q    <= '0;
      period_cnt_q <= '0;
      abort_cnt_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_reg_q    <= cfg_reg_d;
      period_cnt_q <= period_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Next state plus all strobes; stream paths are combinational in RUN only.
  always_comb begin
    state_d      = state_q;
    cfg_reg_d    = cfg_reg_q;
    period_cnt_d = period_cnt_q;
    abort_cnt_d  = abort_cnt_q;
    cfg_err_d    = 1'b0;
    abort_hold   = 1'b0;
    cfg_ready    = 1'b0;
    qb_start     = 1'b0;
    done         = 1'b0;
    src_ready    = 1'b0;
    qb_we        = 1'b0;
    qb_data_in   = '0;
    snk_valid    = 1'b0;
    snk_data     = '0;
    qb_re        = 1'b0;
    snk_nxcol    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          cfg_reg_d = cfg_bits;
          if (cfg_bad) cfg_err_d = 1'b1;
          else         state_d   = ST_START;
        end
      end
      ST_START: begin
        qb_start = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        src_ready  = qb_wrdy;
        qb_we      = src_valid & qb_wrdy;
        qb_data_in = src_data;
        snk_valid  = qb_rrdy;
        snk_data   = qb_data_out;
        qb_re      = snk_ready;
        snk_nxcol  = qb_nxcol;
        // A swcol read closes a period; the last one closes the job.
        if (snk_ready && qb_rrdy && qb_swcol) begin
          if (period_cnt_q == nper_m1) begin
            period_cnt_d = '0;
            state_d      = ST_DONE;
          end else begin
            period_cnt_d = period_cnt_q + NPER_W'(1);
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        abort_hold   = 1'b1;
        period_cnt_d = '0;
        if (abort_cnt_q) begin
          abort_cnt_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          abort_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides whatever transition the active job wanted this cycle.
    if (abort && (state_q == ST_START || state_q == ST_RUN || state_q == ST_DONE)) begin
      state_d      = ST_ABORT;
      period_cnt_d = '0;
      abort_cnt_d  = 1'b0;
    end
  end

  assign qb_rst_n       = rst & ~abort_hold;
  assign qb_config_bits = cfg_reg_q;
  assign busy           = (state_q != ST_IDLE);
  assign cfg_err        = cfg_err_q;

`ifdef QUADRABUF_CTRL_STATS_EN
  quadrabuf_ctrl_stats u_stats (
    .clk            (clk),
    .rst            (rst),
    .clr_i          (state_q == ST_START),
    .wr_stall_i     ((state_q == ST_RUN) & src_valid & ~qb_wrdy),
    .rd_stall_i     ((state_q == ST_RUN) & snk_ready & ~qb_rrdy),
    .wr_stall_cnt_o (wr_stall_cnt),
    .rd_stall_cnt_o (rd_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_quadrabuf_ctrl.sv
// Directed bench for quadrabuf_ctrl with a small behavioural buffer model.
// Expected read words are queued when a job is launched and popped as the
// sink accepts them.
module tb_quadrabuf_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid, cfg_ready, abort;
  logic [40:0] cfg_bits, qb_config_bits;
  logic        src_valid, src_ready, snk_valid, snk_ready, snk_nxcol;
  logic [15:0] src_data, snk_data, qb_data_in, qb_data_out;
  logic        qb_rst_n, qb_start, qb_we, qb_re;
  logic        qb_wrdy, qb_rrdy, qb_swcol, qb_nxcol;
  logic        busy, done, cfg_err;
`ifdef QUADRABUF_CTRL_STATS_EN
  logic [31:0] wr_stall_cnt, rd_stall_cnt;
`endif

  quadrabuf_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bits(cfg_bits), .abort(abort),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready), .snk_nxcol(snk_nxcol),
    .qb_rst_n(qb_rst_n), .qb_config_bits(qb_config_bits), .qb_start(qb_start),
    .qb_we(qb_we), .qb_re(qb_re), .qb_data_in(qb_data_in),
    .qb_wrdy(qb_wrdy), .qb_rrdy(qb_rrdy), .qb_swcol(qb_swcol), .qb_nxcol(qb_nxcol),
    .qb_data_out(qb_data_out),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef QUADRABUF_CTRL_STATS_EN
    , .wr_stall_cnt(wr_stall_cnt), .rd_stall_cnt(rd_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Buffer model: k-th word since buffer reset is {4'hA, k}; swcol on the
  // last word of each period.
  int rd_idx;
  int per_len = 12;
  always @(posedge clk or negedge qb_rst_n)
    if (!qb_rst_n)             rd_idx <= 0;
    else if (qb_re && qb_rrdy) rd_idx <= rd_idx + 1;
  assign qb_data_out = {4'hA, rd_idx[11:0]};
  assign qb_swcol    = (((rd_idx + 1) % per_len) == 0);
  assign qb_nxcol    = rd_idx[2];

  logic [15:0] sb[$];
  int exp_idx = 0;
  int n_assert = 0, n_fail = 0;
  int cyc_n = 0, n_start = 0, n_done = 0, n_err = 0, n_reads = 0, n_wr = 0, n_qbrst = 0;
  int done_cyc = -100, sw_cyc = -100;

  function automatic logic [40:0] pack(input int nc, input int nr, input int np, input int nd);
    return {2'(nc), 10'(nr), 19'(np), 10'(nd)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe one cycle just after the input update, then move to the next negedge.
  task automatic cyc();
    #1;
    cyc_n++;
    if (qb_start) n_start++;
    if (done) begin n_done++; done_cyc = cyc_n; end
    if (cfg_err) n_err++;
    if (!qb_rst_n) n_qbrst++;
    if (!busy) chk("idle_gate", {src_ready, qb_we, qb_re, snk_valid, snk_nxcol}, 0);
    if (qb_we) begin n_wr++; chk("wr_data", qb_data_in, src_data); end
    if (snk_valid) begin
      chk("re_follow", qb_re, snk_ready);
      chk("src_rdy", src_ready, qb_wrdy);
      chk("we_gate", qb_we, src_valid & qb_wrdy);
      chk("nxcol", snk_nxcol, qb_nxcol);
    end
    if (snk_valid && snk_ready) begin
      n_reads++;
      if (qb_swcol) sw_cyc = cyc_n;
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) chk("rd_data", snk_data, sb.pop_front());
    end else if (snk_valid && sb.size() > 0) begin
      chk("stall_hold", snk_data, sb[0]);
    end
    @(negedge clk);
  endtask

  task automatic start_job(input int nc, input int nr, input int np, input int nd);
    int total;
    src_valid = 0; snk_ready = 0;
    per_len = nd * nc * nr;
    total = per_len * np;
    for (int k = 0; k < total; k++) begin
      int kk;
      kk = exp_idx + k;
      sb.push_back({4'hA, kk[11:0]});
    end
    exp_idx += total;
    n_start = 0; n_done = 0; n_reads = 0; n_wr = 0; done_cyc = -100; sw_cyc = -100;
    chk("cfg_rdy_idle", cfg_ready, 1);
    cfg_valid = 1; cfg_bits = pack(nc, nr, np, nd);
    cyc();
    cfg_valid = 0;
    chk("cfg_rdy_drop", cfg_ready, 0);
    chk("start_hi", qb_start, 1);
    chk("busy_start", busy, 1);
    cyc();
    chk("start_lo", qb_start, 0);
  endtask

  task automatic run_done(input bit bp, input int nreads);
    src_valid = 1; snk_ready = 1; qb_wrdy = 1; qb_rrdy = 1;
    for (int c = 0; c < 300 && n_done == 0; c++) begin
      if (bp) begin snk_ready = (c % 2 == 0); qb_wrdy = (c % 3 != 2); end
      src_data = 16'(c * 7 + 3);
      cyc();
    end
    chk("job_done", n_done, 1);
    chk("job_start_once", n_start, 1);
    chk("job_reads", n_reads, nreads);
    chk("done_lat", done_cyc, sw_cyc + 1);
    chk("sb_drained", sb.size(), 0);
    chk("writes_seen", n_wr > 0, 1);
    src_valid = 0; snk_ready = 0; qb_wrdy = 1;
    cyc();
    chk("post_busy", busy, 0);
    chk("post_cfg_rdy", cfg_ready, 1);
    chk("done_single", n_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_valid = 0; cfg_bits = '0; abort = 0;
    src_valid = 1; src_data = 16'h1234; snk_ready = 1; qb_wrdy = 1; qb_rrdy = 1;
    @(negedge clk); #1;
    chk("rst_outs", {src_ready, qb_we, qb_re, snk_valid, qb_start, done, cfg_err, busy, snk_nxcol}, 0);
    chk("rst_cfg_rdy", cfg_ready, 1);
    chk("rst_qb_rst_n", qb_rst_n, 0);
    chk("rst_cfg_bits", qb_config_bits, 0);
    chk("rst_data", {snk_data, qb_data_in}, 0);
    @(negedge clk);
    rst = 1; src_valid = 0; snk_ready = 0;

    // Bad config: nCol = 0.
    n_err = 0; n_start = 0;
    cfg_valid = 1; cfg_bits = pack(0, 2, 1, 4);
    cyc();
    cfg_valid = 0;
    repeat (3) cyc();
    chk("bad_err_once", n_err, 1);
    chk("bad_no_start", n_start, 0);
    chk("bad_idle", busy, 0);
    chk("bad_cfg_rdy", cfg_ready, 1);
    chk("bad_latched", qb_config_bits, pack(0, 2, 1, 4));
    chk("qb_rst_n_run", qb_rst_n, 1);

    // Single-period job, then two-period job, then sink/source backpressure.
    start_job(3, 1, 1, 4);
    chk("cfg_bits_out", qb_config_bits, pack(3, 1, 1, 4));
    run_done(0, 12);
    start_job(3, 1, 2, 4);
    run_done(0, 24);
    start_job(3, 1, 1, 4);
    run_done(1, 12);

    // Abort after five reads.
    start_job(3, 1, 2, 4);
    src_valid = 1; snk_ready = 1; qb_wrdy = 1; qb_rrdy = 1;
    for (int c = 0; c < 50 && n_reads < 5; c++) cyc();
    chk("abort_pre_reads", n_reads, 5);
    abort = 1; snk_ready = 0; n_qbrst = 0; n_done = 0;
    cyc();
    abort = 0;
    chk("abort_qb_rst_n", qb_rst_n, 0);
    chk("abort_strobes", {qb_we, src_ready, qb_re, snk_valid, qb_start, done}, 0);
    chk("abort_busy", busy, 1);
    repeat (5) cyc();
    chk("abort_hold_len", n_qbrst, 2);
    chk("abort_no_done", n_done, 0);
    chk("abort_idle", busy, 0);
    chk("abort_cfg_rdy", cfg_ready, 1);
    sb.delete(); exp_idx = 0;
    start_job(3, 1, 1, 4);
    run_done(0, 12);

    // Asynchronous reset in the middle of a job.
    start_job(3, 1, 1, 4);
    src_valid = 1; snk_ready = 1; qb_wrdy = 1; qb_rrdy = 1;
    repeat (3) cyc();
    #2 rst = 0;
    #1;
    chk("arst_outs", {src_ready, qb_we, qb_re, snk_valid, qb_start, done, cfg_err, busy, snk_nxcol}, 0);
    chk("arst_data", {snk_data, qb_data_in}, 0);
    chk("arst_cfg_rdy", cfg_ready, 1);
    chk("arst_qb_rst_n", qb_rst_n, 0);
    chk("arst_cfg_bits", qb_config_bits, 0);
    sb.delete(); exp_idx = 0;
    @(negedge clk);
    rst = 1; src_valid = 0; snk_ready = 0;
    cyc();
    chk("arst_rel_cfg_rdy", cfg_ready, 1);
    chk("arst_rel_busy", busy, 0);
    chk("arst_rel_qb_rst_n", qb_rst_n, 1);

`ifdef QUADRABUF_CTRL_STATS_EN
    // Stall counters: three cycles of stalled reads and writes.
    start_job(3, 1, 1, 4);
    chk("stats_clear_rd", rd_stall_cnt, 0);
    chk("stats_clear_wr", wr_stall_cnt, 0);
    snk_ready = 1; qb_rrdy = 0; src_valid = 1; qb_wrdy = 0;
    repeat (3) cyc();
    snk_ready = 0; src_valid = 0;
    #1;
    chk("rd_stall_cnt", rd_stall_cnt, 3);
    chk("wr_stall_cnt", wr_stall_cnt, 3);
    qb_rrdy = 1; qb_wrdy = 1;
    abort = 1;
    cyc();
    abort = 0;
    repeat (3) cyc();
    sb.delete(); exp_idx = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
